// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard beside the ID stage: tracks in-flight destinations
// with fixed-latency countdowns or a wait-for-writeback code and stalls decode on RAW/WAW.
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int REG_W  = 5,
    parameter int LAT_W  = 3,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [REG_W-1:0]  dec_rs1,
    input  logic              dec_rs1_used,
    input  logic [REG_W-1:0]  dec_rs2,
    input  logic              dec_rs2_used,
    input  logic [REG_W-1:0]  dec_rd,
    input  logic              dec_rd_we,
    input  logic [LAT_W-1:0]  dec_lat,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              flush,
    output logic              stall,
    output logic              issue,
    output logic [NREG-1:0]   busy_vec,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [LAT_W-1:0] LAT_VAR = '1;

    logic [LAT_W-1:0]       cnt [NREG];
    logic [2**REG_W-1:0]    busy_pad;
    logic                   hazard;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    // Indices beyond NREG (when NREG < 2**REG_W) read as never busy.
    always_comb begin
        busy_pad = '0;
        busy_pad[NREG-1:0] = busy_vec;
    end

    always_comb begin
        hazard = (dec_rs1_used & busy_pad[dec_rs1])
               | (dec_rs2_used & busy_pad[dec_rs2])
               | (dec_rd_we    & busy_pad[dec_rd]);
        stall  = dec_valid & ~flush & hazard;
        issue  = dec_valid & ~flush & ~hazard;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                // A new producer wins over a same-cycle writeback or decrement.
                if (issue && dec_rd_we && (dec_rd == REG_W'(r)) && (dec_lat != '0)) begin
                    cnt[r] <= dec_lat;
                end else if (wb_valid && (wb_rd == REG_W'(r)) && (cnt[r] == LAT_VAR)) begin
                    cnt[r] <= '0;
                end else if ((cnt[r] != '0) && (cnt[r] != LAT_VAR)) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised per-register scoreboard that replaces single-load-use stall detection.
- Tracks every in-flight destination register with a countdown or a wait-for-writeback flag.
- Raises a decode-stage stall on RAW hazards (rs1/rs2) and WAW hazards (rd) against any outstanding producer, not only the instruction directly ahead.
- Sits beside the ID stage. Fed by decode fields, the writeback return bus and the pipeline flush.

Parameters:
NREG, 32, number of architectural registers; register 0 is hardwired zero and never busy
REG_W, 5, register index width; must satisfy 2**REG_W >= NREG
LAT_W, 3, latency field width; all-ones code LAT_VAR = variable latency, cleared only by writeback
PERF_W, 32, width of stall-cycle performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
dec_valid  input  1  valid instruction in ID
dec_rs1  input  REG_W  source 1 index
dec_rs1_used  input  1  instruction reads rs1
dec_rs2  input  REG_W  source 2 index
dec_rs2_used  input  1  instruction reads rs2
dec_rd  input  REG_W  destination index
dec_rd_we  input  1  instruction writes rd
dec_lat  input  LAT_W  cycles until result is forwardable; 0 = no tracking; LAT_VAR = wait for wb
wb_valid  input  1  variable-latency result returned
wb_rd  input  REG_W  register returned
flush  input  1  squash instruction in ID (branch redirect)
stall  output  1  hold PC and IF/ID, insert bubble into ID/EX
issue  output  1  instruction leaves ID this cycle
busy_vec  output  NREG  per-register busy flag (count != 0)
stall_cnt  output  PERF_W  cycles with stall asserted

Behaviour:
- Reset (sync, rst=1 at edge): all counters 0, busy_vec=0, stall_cnt=0. stall and issue are combinational and therefore 0 while the state is clear and dec_valid=0.
- Per-register state cnt[r] is LAT_W bits. busy[r] = (cnt[r] != 0). cnt[0] is always 0; writes to index 0 are ignored.
- stall (combinational) = dec_valid & ~flush & ( (rs1_used & busy[rs1]) | (rs2_used & busy[rs2]) | (rd_we & busy[rd]) ). Index 0 never stalls.
- issue = dec_valid & ~flush & ~stall.
- Next-state per register r, evaluated each edge:
  - Priority 1: issue & rd_we & rd==r & r!=0 & dec_lat!=0. cnt <= dec_lat. A new producer overrides a same-cycle wb or decrement.
  - Priority 2: wb_valid & wb_rd==r & cnt==LAT_VAR. cnt <= 0.
  - Priority 3: cnt!=0 & cnt!=LAT_VAR. cnt <= cnt-1.
  - Otherwise hold.
- wb_valid to a register that is not in the LAT_VAR state is ignored. No error output.
- Timing contract: a producer issued at edge T with lat L blocks consumers in ID for cycles T+1..T+L and releases at T+L+1.
  - Classic load-use (L=1) gives exactly one bubble.
  - L=1 result is forwarded from MEM/WB by the forwarding unit; this block does not forward.
- WAW stall guarantees at most one outstanding producer per register, so a single counter is sufficient.
- flush suppresses issue and stall in the same cycle. Already-issued entries are not cleared: they are past ID and will complete.
- Reset mid-operation clears all entries, including LAT_VAR ones. A late wb after reset is ignored.
- stall_cnt increments by 1 each cycle stall=1 and saturates at all-ones.
- Dependency check uses current state only; same-cycle wb does not bypass into stall (one-cycle release delay after wb).

Test Plan:
- Reset: rst=1 2 cycles with random inputs -> busy_vec=0, stall_cnt=0, and with dec_valid=0 stall=0 and issue=0.
- Load-use: issue rd=5 lat=1, next cycle rs1=5 used -> stall=1 exactly 1 cycle, then issue=1. Same with lat=3 -> stall 3 cycles, stall_cnt=3.
- Variable latency: issue rd=7 lat=LAT_VAR, consumer rs2=7 -> stall held indefinitely. wb_valid rd=7 at cycle N -> busy[7]=0 at N+1, stall drops at N+1.
- WAW and x0: rd=9 pending lat=LAT_VAR, new instr rd_we rd=9 -> stall. Instruction with rd=0 lat=2 -> busy_vec unchanged. Consumer rs1=0 -> no stall.
- Simultaneous: wb_valid rd=4 and issue rd=4 lat=2 in the same cycle -> cnt[4]=2 (issue wins). wb_rd=6 while cnt[6]=2 (fixed) -> ignored, decrement continues.
- Flush/reset mid-operation: hazard present with flush=1 -> stall=0, issue=0, no new entry. rst while rd=3 is LAT_VAR -> busy_vec=0; later wb rd=3 has no effect.
